// File: rtl/lmg_host_master.sv
// lmg_host_master: Avalon-MM master that loads a board into the move-generator control
// slave, starts it, polls for done and streams the move list out. Optional macro: LMG_HOST_TIMEOUT_EN.
module lmg_host_master #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 13,
  parameter int READ_CYCLES = 3,
  parameter int MAX_MOVES   = 100,
  parameter int POLL_LIMIT  = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [255:0]            cmd_board,
  input  logic [2:0]              cmd_ep_col,
  output logic [ADDR_WIDTH-1:0]   master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [DATA_WIDTH-1:0]   master_writedata,
  output logic [DATA_WIDTH/8-1:0] master_byteenable,
  input  logic [DATA_WIDTH-1:0]   master_readdata,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic                    res_last,
  output logic                    busy,
  output logic [7:0]              count,
  output logic                    error
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_BOARD  = 4'd1,
    S_WR_CTRL   = 4'd2,
    S_WR_START  = 4'd3,
    S_POLL      = 4'd4,
    S_RD_COUNT  = 4'd5,
    S_RD_MOVES  = 4'd6,
    S_RES_OUT   = 4'd7,
    S_CLR_START = 4'd8
  } state_t;

  localparam logic [7:0]            CYC_LAST   = 8'(READ_CYCLES - 1);
  localparam logic [7:0]            MAX_CNT    = 8'(MAX_MOVES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BOARD = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MOVES = ADDR_WIDTH'(17);

  state_t                  state_r, state_nxt_s;
  logic [7:0]              idx_r, idx_nxt_s;
  logic [7:0]              cyc_r, cyc_nxt_s;
  logic [255:0]            board_r, board_nxt_s;
  logic [2:0]              ep_r, ep_nxt_s;
  logic [7:0]              count_r, count_nxt_s;
  logic                    rd_last_s;
  logic                    poll_expired_s;
  logic [7:0]              clamp_s;

  logic                    cmd_ready_r, busy_r, read_r, write_r, res_valid_r, res_last_r;
  logic [ADDR_WIDTH-1:0]   address_r;
  logic [DATA_WIDTH-1:0]   wdata_r, res_data_r;
  logic                    rd_nxt_s, wr_nxt_s, res_last_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic [DATA_WIDTH-1:0]   wdata_nxt_s, ctrl_s, res_data_nxt_s;

  assign rd_last_s = (cyc_r == CYC_LAST);
  assign clamp_s   = (master_readdata > DATA_WIDTH'(MAX_MOVES)) ? MAX_CNT : master_readdata[7:0];

`ifdef LMG_HOST_TIMEOUT_EN
  logic [15:0] poll_cnt_r;
  logic        error_r;

  // Poll-read counter and sticky timeout flag, cleared by the next accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt_r <= 16'd0;
      error_r    <= 1'b0;
    end else begin
      if (state_r == S_WR_START) begin
        poll_cnt_r <= 16'd0;
      end else if (state_r == S_POLL && rd_last_s) begin
        poll_cnt_r <= poll_cnt_r + 16'd1;
      end else begin
        poll_cnt_r <= poll_cnt_r;
      end
      if (state_r == S_IDLE && cmd_valid) begin
        error_r <= 1'b0;
      end else if (state_r == S_POLL && rd_last_s && !master_readdata[1] && poll_expired_s) begin
        error_r <= 1'b1;
      end else begin
        error_r <= error_r;
      end
    end
  end

  assign poll_expired_s = (poll_cnt_r == 16'(POLL_LIMIT - 1));
  assign error          = error_r;
`else
  assign poll_expired_s = 1'b0;
  assign error          = 1'b0;
`endif

  // State register plus the job context it walks through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      idx_r   <= 8'd0;
      cyc_r   <= 8'd0;
      board_r <= 256'd0;
      ep_r    <= 3'd0;
      count_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cyc_r   <= cyc_nxt_s;
      board_r <= board_nxt_s;
      ep_r    <= ep_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state logic: idx_r counts board words, then moves; cyc_r times each read.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cyc_nxt_s   = cyc_r;
    board_nxt_s = board_r;
    ep_nxt_s    = ep_r;
    count_nxt_s = count_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt_s = S_WR_BOARD;
          idx_nxt_s   = 8'd0;
          board_nxt_s = cmd_board;
          ep_nxt_s    = cmd_ep_col;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WR_BOARD: begin
        if (idx_r == 8'd7) begin
          state_nxt_s = S_WR_CTRL;
        end else begin
          idx_nxt_s = idx_r + 8'd1;
        end
      end
      S_WR_CTRL:  state_nxt_s = S_WR_START;
      S_WR_START: begin
        state_nxt_s = S_POLL;
        cyc_nxt_s   = 8'd0;
      end
      S_POLL: begin
        if (rd_last_s) begin
          cyc_nxt_s = 8'd0;
          if (master_readdata[1]) begin
            state_nxt_s = S_RD_COUNT;
          end else if (poll_expired_s) begin
            state_nxt_s = S_CLR_START;
          end else begin
            state_nxt_s = S_POLL;
          end
        end else begin
          cyc_nxt_s = cyc_r + 8'd1;
        end
      end
      S_RD_COUNT: begin
        if (rd_last_s) begin
          cyc_nxt_s   = 8'd0;
          idx_nxt_s   = 8'd0;
          count_nxt_s = clamp_s;
          if (clamp_s == 8'd0) begin
            state_nxt_s = S_CLR_START;
          end else begin
            state_nxt_s = S_RD_MOVES;
          end
        end else begin
          cyc_nxt_s = cyc_r + 8'd1;
        end
      end
      S_RD_MOVES: begin
        if (rd_last_s) begin
          state_nxt_s = S_RES_OUT;
        end else begin
          cyc_nxt_s = cyc_r + 8'd1;
        end
      end
      S_RES_OUT: begin
        if (res_ready) begin
          cyc_nxt_s = 8'd0;
          if (idx_r == count_r - 8'd1) begin
            state_nxt_s = S_CLR_START;
          end else begin
            state_nxt_s = S_RD_MOVES;
            idx_nxt_s   = idx_r + 8'd1;
          end
        end else begin
          state_nxt_s = S_RES_OUT;
        end
      end
      S_CLR_START: state_nxt_s = S_IDLE;
      default:     state_nxt_s = S_IDLE;
    endcase
  end

  // Output logic: computed from the next state so every output lands in a register.
  always_comb begin
    wr_nxt_s       = 1'b0;
    rd_nxt_s       = 1'b0;
    addr_nxt_s     = ADDR_CTRL;
    wdata_nxt_s    = {DATA_WIDTH{1'b0}};
    ctrl_s         = DATA_WIDTH'({ep_nxt_s, 5'b00000});
    res_data_nxt_s = res_data_r;
    res_last_nxt_s = res_last_r;
    case (state_nxt_s)
      S_WR_BOARD: begin
        wr_nxt_s    = 1'b1;
        addr_nxt_s  = ADDR_BOARD + ADDR_WIDTH'(idx_nxt_s);
        wdata_nxt_s = DATA_WIDTH'(board_nxt_s[{idx_nxt_s[2:0], 5'd0} +: 32]);
      end
      S_WR_CTRL, S_CLR_START: begin
        wr_nxt_s    = 1'b1;
        wdata_nxt_s = ctrl_s;
      end
      S_WR_START: begin
        wr_nxt_s    = 1'b1;
        wdata_nxt_s = ctrl_s | DATA_WIDTH'(1);
      end
      S_POLL: rd_nxt_s = 1'b1;
      S_RD_COUNT: begin
        rd_nxt_s   = 1'b1;
        addr_nxt_s = ADDR_COUNT;
      end
      S_RD_MOVES: begin
        rd_nxt_s   = 1'b1;
        addr_nxt_s = ADDR_MOVES + ADDR_WIDTH'(idx_nxt_s);
      end
      default: begin
        wr_nxt_s = 1'b0;
        rd_nxt_s = 1'b0;
      end
    endcase
    if (state_r == S_RD_MOVES && rd_last_s) begin
      res_data_nxt_s = master_readdata;
      res_last_nxt_s = (idx_r == count_r - 8'd1);
    end else if (res_valid_r && res_ready) begin
      res_last_nxt_s = 1'b0;
    end else begin
      res_last_nxt_s = res_last_r;
    end
  end

  // Output registers; reset releases the bus in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      read_r      <= 1'b0;
      write_r     <= 1'b0;
      address_r   <= ADDR_CTRL;
      wdata_r     <= {DATA_WIDTH{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {DATA_WIDTH{1'b0}};
      res_last_r  <= 1'b0;
    end else begin
      cmd_ready_r <= (state_nxt_s == S_IDLE);
      busy_r      <= (state_nxt_s != S_IDLE);
      read_r      <= rd_nxt_s;
      write_r     <= wr_nxt_s;
      address_r   <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      res_valid_r <= (state_nxt_s == S_RES_OUT);
      res_data_r  <= res_data_nxt_s;
      res_last_r  <= res_last_nxt_s;
    end
  end

  assign cmd_ready         = cmd_ready_r;
  assign busy              = busy_r;
  assign master_read       = read_r;
  assign master_write      = write_r;
  assign master_address    = address_r;
  assign master_writedata  = wdata_r;
  assign master_byteenable = {(DATA_WIDTH/8){1'b1}};
  assign res_valid         = res_valid_r;
  assign res_data          = res_data_r;
  assign res_last          = res_last_r;
  assign count             = count_r;

endmodule

// File: tb/tb_lmg_host_master.sv
// Bench for lmg_host_master: a job table driven against a small control-slave model,
// with write/result scoreboards plus hand sequences for backpressure, timeout and reset.
module tb_lmg_host_master;

  typedef struct {
    logic [2:0]  ep;
    logic [31:0] row_base;
    logic [31:0] n;
    int          delay;
    logic [31:0] move_base;
    bit          bp;
    logic [7:0]  exp_count;
    bit          exp_err;
  } job_t;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] data;
    int          off;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready;
  logic [255:0] cmd_board;
  logic [2:0]   cmd_ep_col;
  logic [12:0]  master_address;
  logic         master_read, master_write;
  logic [31:0]  master_writedata, master_readdata;
  logic [3:0]   master_byteenable;
  logic         res_valid, res_ready, res_last, busy, error;
  logic [31:0]  res_data;
  logic [7:0]   count;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int accept_cyc = 0, last_wr_cyc = 0, poll_cyc = 0, move_reads = 0, res_seen = 0;
  bit first_rd = 1'b0, bp_en = 1'b0, bp_done = 1'b0;
  logic        prev_rd = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, prev_last = 1'b0;
  logic [12:0] prev_addr = 13'd0;
  logic [31:0] prev_data = 32'd0;
  wr_t  wr_q[$];
  res_t res_q[$];
  job_t jobs[6];

  logic [31:0] sl_ctrl_r = 32'd0;
  logic        sl_done_r = 1'b0;
  int          sl_dcnt_r = 0;
  int          sl_delay = 0;
  logic [31:0] sl_n = 32'd0, sl_base = 32'd0;

  always #5 clk = ~clk;

  lmg_host_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(13), .READ_CYCLES(3), .MAX_MOVES(100), .POLL_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_board(cmd_board), .cmd_ep_col(cmd_ep_col),
    .master_address(master_address), .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_byteenable(master_byteenable),
    .master_readdata(master_readdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .count(count), .error(error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Control-slave model: done rises sl_delay cycles after a start write (0 = never).
  always @(posedge clk) begin
    if (master_write && master_address == 13'd0) begin
      sl_ctrl_r <= master_writedata;
      if (master_writedata[0]) begin
        sl_done_r <= 1'b0;
        sl_dcnt_r <= sl_delay;
      end
    end else if (sl_dcnt_r > 0) begin
      sl_dcnt_r <= sl_dcnt_r - 1;
      if (sl_dcnt_r == 1) sl_done_r <= 1'b1;
    end
  end

  always_comb begin
    master_readdata = 32'd0;
    if (master_address == 13'd0)
      master_readdata = {sl_ctrl_r[31:2], sl_done_r, sl_ctrl_r[0]};
    else if (master_address == 13'd16)
      master_readdata = sl_n;
    else if (master_address >= 13'd17)
      master_readdata = sl_base + 32'(master_address - 13'd17);
    else
      master_readdata = 32'd0;
  end

  // Bus and result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (reset) begin
      if (cmd_valid && cmd_ready) begin
        accept_cyc = cyc_n; poll_cyc = 0; move_reads = 0; res_seen = 0; first_rd = 1'b1;
      end
      if (master_read || master_write) check("rw_exclusive", {63'd0, master_read & master_write}, 64'd0);
      if (master_write) begin
        check("byteenable", {60'd0, master_byteenable}, 64'hF);
        last_wr_cyc = cyc_n;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: write addr %0h data %0h, none expected", master_address, master_writedata);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", {51'd0, master_address}, {51'd0, w.addr});
          check("wr_data", {32'd0, master_writedata}, {32'd0, w.data});
          if (w.off >= 0) check("wr_cycle", 64'(cyc_n - accept_cyc), 64'(w.off));
        end
      end
      if (master_read) begin
        if (!prev_rd || master_address != prev_addr) begin
          if (master_address >= 13'd17) move_reads++;
          if (first_rd) begin
            first_rd = 1'b0;
            check("poll_start_cycle", 64'(cyc_n - accept_cyc), 64'd11);
            check("poll_addr", {51'd0, master_address}, 64'd0);
          end
        end
        if (master_address == 13'd0) poll_cyc++;
      end
      if (res_valid) begin
        check("res_bus_idle", {63'd0, master_read | master_write}, 64'd0);
        if (prev_valid && !prev_hs) begin
          check("res_data_stable", {32'd0, res_data}, {32'd0, prev_data});
          check("res_last_stable", {63'd0, res_last}, {63'd0, prev_last});
        end
        if (res_ready) begin
          res_seen++;
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL res_unexpected: result %0h, none expected", res_data);
          end else begin
            r = res_q.pop_front();
            check("res_data", {32'd0, res_data}, {32'd0, r.data});
            check("res_last", {63'd0, res_last}, {63'd0, r.last});
          end
        end
      end
      prev_rd = master_read; prev_addr = master_address;
      prev_valid = res_valid; prev_hs = res_valid && res_ready;
      prev_data = res_data; prev_last = res_last;
    end else begin
      prev_rd = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
    end
  end

  // Result sink: stalls 20 cycles on the second move when backpressure is enabled.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en && !bp_done && res_valid && res_seen == 1) begin
        res_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 res_ready = 1'b1;
        bp_done = 1'b1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    check({tag, "_read"}, {63'd0, master_read}, 64'd0);
    check({tag, "_write"}, {63'd0, master_write}, 64'd0);
    check({tag, "_addr"}, {51'd0, master_address}, 64'd0);
    check({tag, "_wdata"}, {32'd0, master_writedata}, 64'd0);
    check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
    check({tag, "_res_last"}, {63'd0, res_last}, 64'd0);
    check({tag, "_res_data"}, {32'd0, res_data}, 64'd0);
    check({tag, "_count"}, {56'd0, count}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
  endtask

  task automatic push_writes(input job_t j, input bit with_clear);
    wr_t w;
    for (int k = 0; k < 8; k++) begin
      w.addr = 13'(2 + k); w.data = j.row_base + 32'(k); w.off = k + 1;
      wr_q.push_back(w);
    end
    w.addr = 13'd0; w.data = {24'd0, j.ep, 5'd0}; w.off = 9;  wr_q.push_back(w);
    w.addr = 13'd0; w.data = {24'd0, j.ep, 5'd1}; w.off = 10; wr_q.push_back(w);
    if (with_clear) begin
      w.addr = 13'd0; w.data = {24'd0, j.ep, 5'd0}; w.off = -1; wr_q.push_back(w);
    end
  endtask

  // Offers the command, then scrambles the inputs while still valid (busy must ignore them).
  task automatic drive_cmd(input job_t j, input int hold);
    sl_delay = j.delay; sl_n = j.n; sl_base = j.move_base; bp_en = j.bp; bp_done = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_ep_col = j.ep;
    for (int k = 0; k < 8; k++) cmd_board[32*k +: 32] = j.row_base + 32'(k);
    @(posedge clk); #1;
    cmd_board = ~cmd_board; cmd_ep_col = ~cmd_ep_col;
    repeat (hold) @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_job(input job_t j, input string tag);
    res_t r;
    int   t;
    push_writes(j, 1'b1);
    for (int i = 0; i < int'(j.exp_count); i++) begin
      r.data = j.move_base + 32'(i); r.last = (i == int'(j.exp_count) - 1);
      res_q.push_back(r);
    end
    drive_cmd(j, 3);
    @(negedge clk);
    check({tag, "_error_cleared"}, {63'd0, error}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    t = 0;
    while (!cmd_ready && t < 5000) begin
      @(negedge clk); t++;
    end
    check({tag, "_job_done"}, {63'd0, cmd_ready}, 64'd1);
    check({tag, "_ready_after_clr"}, 64'(cyc_n - last_wr_cyc), 64'd1);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_count"}, {56'd0, count}, {56'd0, j.exp_count});
    check({tag, "_error"}, {63'd0, error}, {63'd0, j.exp_err});
    check({tag, "_move_reads"}, 64'(move_reads), 64'(j.exp_count));
    check({tag, "_writes_left"}, 64'(wr_q.size()), 64'd0);
    check({tag, "_results_left"}, 64'(res_q.size()), 64'd0);
    if (j.bp) check({tag, "_bp_applied"}, {63'd0, bp_done}, 64'd1);
    wr_q.delete(); res_q.delete();
    bp_en = 1'b0;
  endtask

  initial begin
    int t;
`ifdef LMG_HOST_TIMEOUT_EN
    job_t tj;
`endif
    jobs[0] = '{3'd2, 32'h1000_0000, 32'd3,   50, 32'h0000_000A, 1'b0, 8'd3,   1'b0};
    jobs[1] = '{3'd5, 32'h2222_0000, 32'd0,   10, 32'h0000_0000, 1'b0, 8'd0,   1'b0};
    jobs[2] = '{3'd0, 32'h3333_0000, 32'd150,  5, 32'h0000_1000, 1'b0, 8'd100, 1'b0};
    jobs[3] = '{3'd7, 32'h4444_0000, 32'd3,   20, 32'h0000_0020, 1'b1, 8'd3,   1'b0};
    jobs[4] = '{3'd1, 32'h5555_0000, 32'd100,  3, 32'h0000_0500, 1'b0, 8'd100, 1'b0};
    jobs[5] = '{3'd6, 32'h6666_0000, 32'd1,    7, 32'h0000_0777, 1'b0, 8'd1,   1'b0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_board = 256'd0; cmd_ep_col = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) run_job(jobs[i], $sformatf("job%0d", i));

`ifdef LMG_HOST_TIMEOUT_EN
    tj = '{3'd3, 32'h7777_0000, 32'd0, 0, 32'd0, 1'b0, 8'd0, 1'b1};
    run_job(tj, "timeout");
    check("timeout_poll_cycles", 64'(poll_cyc), 64'd24);
    run_job(jobs[0], "after_timeout");
`endif

    // Reset pulse while the master is polling a slave that never finishes.
    push_writes('{3'd4, 32'h8888_0000, 32'd0, 0, 32'd0, 1'b0, 8'd0, 1'b0}, 1'b0);
    drive_cmd('{3'd4, 32'h8888_0000, 32'd0, 0, 32'd0, 1'b0, 8'd0, 1'b0}, 0);
    t = 0;
    while (poll_cyc < 5 && t < 200) begin
      @(negedge clk); t++;
    end
    check("midrst_polling", 64'(poll_cyc >= 5), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    check("midrst_writes_left", 64'(wr_q.size()), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    wr_q.delete(); res_q.delete();
    run_job(jobs[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
